// File: rtl/bitcell_write_seq.sv
// Write sequencer for a bank of DQ latch words: setup -> enable pulse -> hold,
// then reads the addressed latch word back and flags any mismatch.
module bitcell_write_seq #(
    parameter int WIDTH     = 4,
    parameter int WORDS     = 4,
    parameter int ADDR_W    = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       d,
    output logic [WORDS-1:0]       en,
    input  logic [WORDS*WIDTH-1:0] q,
    output logic                   done,
    output logic                   err,
    input  logic                   err_clr
);

    localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAXC   = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CNT_W  = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CNT_W-1:0] LD_S = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_P = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_H = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [ADDR_W-1:0]  addr, addr_n;
    logic [WIDTH-1:0]   data, data_n;
    logic [WIDTH-1:0]   d_n;
    logic [WORDS-1:0]   en_n;
    logic               err_n;
    logic [WORDS-1:0]   sel;
    logic [WIDTH-1:0]   rd_word;
    logic               addr_ok;

    // Out-of-range addresses decode to an all-zero select, which keeps en low
    // and marks the request as bad in CHECK.
    always_comb begin
        sel     = '0;
        rd_word = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (addr == ADDR_W'(i)) begin
                sel[i]  = 1'b1;
                rd_word = q[i*WIDTH +: WIDTH];
            end
        end
    end

    assign addr_ok  = |sel;
    assign wr_ready = (state == IDLE);
    assign done     = (state == CHECK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
            data  <= '0;
            d     <= '0;
            en    <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            addr  <= addr_n;
            data  <= data_n;
            d     <= d_n;
            en    <= en_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = addr;
        data_n  = data;
        d_n     = d;
        en_n    = '0;
        err_n   = err;
        if (err_clr) err_n = 1'b0;

        case (state)
            IDLE: begin
                if (wr_valid) begin
                    addr_n  = wr_addr;
                    data_n  = wr_data;
                    d_n     = wr_data;
                    cnt_n   = LD_S;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    cnt_n   = LD_P;
                    en_n    = sel;
                    state_n = PULSE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    cnt_n   = LD_H;
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                    en_n  = sel;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_n = CHECK;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            CHECK: begin
                // Setting err takes priority over a simultaneous err_clr.
                if (!addr_ok || (rd_word != data)) err_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bitcell_write_seq.sv
// Directed plus randomized bench for bitcell_write_seq with a clocked latch-bank
// model per instance and a phase-table reference for expected timing.
module tb_bitcell_write_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       wr_valid [3];
    logic       wr_ready [3];
    logic       done     [3];
    logic       err      [3];
    logic       err_clr  [3];
    logic [1:0] wr_addr  [3];
    logic [3:0] wr_data  [3];
    logic [3:0] d        [3];
    logic [3:0] en       [3];
    logic [3:0] en0, en2;
    logic [2:0] en1;
    logic [15:0] lat     [3];
    logic [15:0] q       [3];
    logic [3:0]  stuck   [3];

    int   checks   = 0;
    int   failures = 0;
    logic err_exp [3];
    int   pcyc    [3] = '{1, 1, 3};
    int   nwords  [3] = '{4, 3, 4};

    assign en[0] = en0;
    assign en[1] = {1'b0, en1};
    assign en[2] = en2;

    initial begin
        for (int k = 0; k < 3; k++) lat[k] = '0;
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++)
                if (en[k][i]) lat[k][i*4 +: 4] <= d[k];
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            q[k] = '0;
            for (int i = 0; i < 4; i++)
                q[k][i*4 +: 4] = stuck[k][i] ? 4'h0 : lat[k][i*4 +: 4];
        end
    end

    bitcell_write_seq u_a (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]),
        .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .d(d[0]), .en(en0),
        .q(q[0]), .done(done[0]), .err(err[0]), .err_clr(err_clr[0])
    );

    bitcell_write_seq #(.WORDS(3)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]),
        .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .d(d[1]), .en(en1),
        .q(q[1][11:0]), .done(done[1]), .err(err[1]), .err_clr(err_clr[1])
    );

    bitcell_write_seq #(.PULSE_CYC(3)) u_c (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid[2]), .wr_ready(wr_ready[2]),
        .wr_addr(wr_addr[2]), .wr_data(wr_data[2]), .d(d[2]), .en(en2),
        .q(q[2]), .done(done[2]), .err(err[2]), .err_clr(err_clr[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the IDLE cycle after done.
    task automatic do_write(input int k, input logic [1:0] a, input logic [3:0] dat,
                            input bit hold, input bit nowait);
        int         waited = 0;
        int         t;
        logic [3:0] rb;
        logic [3:0] en_exp;
        t = pcyc[k] + 3;
        wr_valid[k] = 1'b1;
        wr_addr[k]  = a;
        wr_data[k]  = dat;
        while (!wr_ready[k] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (nowait) chk("spacing", waited, 0);
        chk("ready_before_accept", {31'd0, wr_ready[k]}, 1);
        for (int c = 1; c <= t; c++) begin
            @(negedge clk);
            if (!hold && c == 1) wr_valid[k] = 1'b0;
            en_exp = (c >= 2 && c < 2 + pcyc[k] && int'(a) < nwords[k]) ? 4'(1 << a) : 4'h0;
            chk("en_phase", {28'd0, en[k]}, {28'd0, en_exp});
            chk("d_held", {28'd0, d[k]}, {28'd0, dat});
            chk("ready_busy", {31'd0, wr_ready[k]}, 0);
            chk("done_timing", {31'd0, done[k]}, {31'd0, (c == t)});
        end
        rb = stuck[k][a] ? 4'h0 : dat;
        if (int'(a) >= nwords[k] || rb != dat) err_exp[k] = 1'b1;
        @(negedge clk);
        chk("err_after_done", {31'd0, err[k]}, {31'd0, err_exp[k]});
        chk("ready_idle", {31'd0, wr_ready[k]}, 1);
        chk("en_idle", {28'd0, en[k]}, 0);
        chk("done_idle", {31'd0, done[k]}, 0);
        chk("d_kept", {28'd0, d[k]}, {28'd0, dat});
    endtask

    task automatic clear_err(input int k);
        err_clr[k] = 1'b1;
        @(negedge clk);
        err_clr[k] = 1'b0;
        err_exp[k] = 1'b0;
        chk("err_clr", {31'd0, err[k]}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wr_valid[k] = 1'b0; wr_addr[k] = '0; wr_data[k] = '0;
            err_clr[k]  = 1'b0; stuck[k]   = '0; err_exp[k] = 1'b0;
        end
        wr_valid[0] = 1'b1;
        wr_addr[0]  = 2'd2;
        wr_data[0]  = 4'hF;

        // Reset with a pending request
        repeat (3) begin
            @(negedge clk);
            chk("rst_en", {28'd0, en[0]}, 0);
            chk("rst_d", {28'd0, d[0]}, 0);
            chk("rst_done", {31'd0, done[0]}, 0);
            chk("rst_err", {31'd0, err[0]}, 0);
            chk("rst_ready", {31'd0, wr_ready[0]}, 1);
        end
        wr_valid[0] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_d", {28'd0, d[0]}, 0);
        chk("post_rst_ready", {31'd0, wr_ready[0]}, 1);

        // Single write
        do_write(0, 2'd2, 4'b1011, 1'b0, 1'b0);

        // Back-to-back sweep with wr_valid held
        for (int i = 0; i < 4; i++)
            do_write(0, 2'(i), 4'(i * 5), 1'b1, (i > 0));
        wr_valid[0] = 1'b0;

        // Readback fault on word 1
        stuck[0] = 4'b0010;
        do_write(0, 2'd1, 4'b0110, 1'b0, 1'b0);
        @(negedge clk);
        chk("err_sticky", {31'd0, err[0]}, 1);
        clear_err(0);
        stuck[0] = '0;

        // WORDS=3 instance, in range then out of range
        do_write(1, 2'd0, 4'h9, 1'b0, 1'b0);
        do_write(1, 2'd3, 4'hC, 1'b0, 1'b0);

        // Reset during a long pulse
        wr_valid[2] = 1'b1; wr_addr[2] = 2'd1; wr_data[2] = 4'h3;
        @(negedge clk);
        wr_valid[2] = 1'b0;
        @(negedge clk);
        chk("pulse1_en", {28'd0, en[2]}, 4'b0010);
        @(negedge clk);
        chk("pulse2_en", {28'd0, en[2]}, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        chk("async_en", {28'd0, en[2]}, 0);
        chk("async_d", {28'd0, d[2]}, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done[2]}, 0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) err_exp[k] = 1'b0;
        @(negedge clk);
        chk("abort_no_done_after", {31'd0, done[2]}, 0);
        do_write(2, 2'd3, 4'hA, 1'b0, 1'b0);

        // Randomized writes across instances
        repeat (24) begin
            int         k;
            logic [1:0] a;
            logic [3:0] dat;
            k   = int'($urandom_range(0, 2));
            a   = 2'($urandom_range(0, 3));
            dat = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) stuck[k] = 4'($urandom_range(1, 15));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_write(k, a, dat, 1'b0, 1'b0);
            stuck[k] = '0;
            if (err_exp[k] && $urandom_range(0, 1) == 1) clear_err(k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
